// File: rtl/nvdla_csb_adapter.sv
// Bridges a 32-bit streamer command/response pair onto the NVDLA CSB port.
// One transaction in flight; NVDLA responses are waited for with an abort timeout.
module nvdla_csb_adapter #(
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [31:0] ERR_WORD = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        csb2nvdla_valid_o,
  input  logic        csb2nvdla_ready_i,
  output logic [15:0] csb2nvdla_addr_o,
  output logic [31:0] csb2nvdla_wdat_o,
  output logic        csb2nvdla_write_o,
  output logic        csb2nvdla_nposted_o,
  input  logic        nvdla2csb_valid_i,
  input  logic [31:0] nvdla2csb_data_i,
  input  logic        nvdla2csb_wr_complete_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] GET_DATA = 3'd1;
  localparam logic [2:0] ISSUE    = 3'd2;
  localparam logic [2:0] WAIT_RSP = 3'd3;
  localparam logic [2:0] PUSH_RSP = 3'd4;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  state_q;
  logic        write_q;
  logic        nposted_q;
  logic [15:0] addr_q;
  logic [31:0] wdat_q;
  logic [31:0] rdat_q;
  logic [15:0] cnt_q;
  logic        err_q;
  logic        spurious;

  // Any NVDLA pulse we are not waiting for is dropped and flagged.
  always_comb begin
    spurious = 1'b0;
    if (state_q != WAIT_RSP)
      spurious = nvdla2csb_valid_i | nvdla2csb_wr_complete_i;
    else if (write_q)
      spurious = nvdla2csb_valid_i;
    else
      spurious = nvdla2csb_wr_complete_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      nposted_q <= 1'b0;
      addr_q    <= '0;
      wdat_q    <= '0;
      rdat_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            write_q   <= cmd_data_i[31];
            nposted_q <= cmd_data_i[30];
            addr_q    <= cmd_data_i[15:0];
            state_q   <= cmd_data_i[31] ? GET_DATA : ISSUE;
          end
        end
        GET_DATA: begin
          if (cmd_valid_i) begin
            wdat_q  <= cmd_data_i;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (csb2nvdla_ready_i) begin
            if (!write_q || nposted_q) begin
              cnt_q   <= '0;
              state_q <= WAIT_RSP;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        WAIT_RSP: begin
          cnt_q <= cnt_q + 16'd1;
          // A real response in the final counted cycle wins over the timeout.
          if (!write_q && nvdla2csb_valid_i) begin
            rdat_q  <= nvdla2csb_data_i;
            state_q <= PUSH_RSP;
          end else if (write_q && nvdla2csb_wr_complete_i) begin
            rdat_q  <= '0;
            state_q <= PUSH_RSP;
          end else if (cnt_q == CNT_LAST) begin
            rdat_q  <= write_q ? 32'h1 : ERR_WORD;
            err_q   <= 1'b1;
            state_q <= PUSH_RSP;
          end
        end
        PUSH_RSP: begin
          if (rsp_ready_i)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (spurious)
        err_q <= 1'b1;
    end
  end

  assign cmd_ready_o         = (state_q == IDLE) || (state_q == GET_DATA);
  assign csb2nvdla_valid_o   = (state_q == ISSUE);
  assign csb2nvdla_addr_o    = addr_q;
  assign csb2nvdla_wdat_o    = wdat_q;
  assign csb2nvdla_write_o   = write_q;
  assign csb2nvdla_nposted_o = nposted_q;
  assign rsp_valid_o         = (state_q == PUSH_RSP);
  assign rsp_data_o          = rdat_q;
  assign busy_o              = (state_q != IDLE);
  assign err_o               = err_q;

endmodule
